// File: rtl/memory.sv
// Frame-buffer pixel memory: one write port, two synchronous read-first read ports.
// Define MEMORY_CLEAR_EN to make reset sweep zeros through the whole array.
module memory #(
    parameter int unsigned DEPTH  = 40000,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memw,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic [ADDR_W-1:0] rmemaddr,
    input  logic [ADDR_W-1:0] rmemaddr2,
    input  logic [DATA_W-1:0] memi,
    output logic [DATA_W-1:0] memo,
    output logic [DATA_W-1:0] memo2
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clearing;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ok;
    logic              ra_ok;
    logic              rb_ok;

    assign wr_ok = {1'b0, memaddr}   < LIMIT;
    assign ra_ok = {1'b0, rmemaddr}  < LIMIT;
    assign rb_ok = {1'b0, rmemaddr2} < LIMIT;

`ifdef MEMORY_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    // Sweep controller: any reset (re)starts at address 0, returns to RUN after LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            if (clr_addr == LAST) begin
                state <= RUN;
            end
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

    assign clearing = (state == CLEAR);
    assign wr_en    = ~rst & (clearing | (memw & wr_ok));
    assign wr_addr  = clearing ? clr_addr : memaddr;
    assign wr_data  = clearing ? '0 : memi;
`else
    assign clearing = 1'b0;
    assign wr_en    = memw & ~rst & wr_ok;
    assign wr_addr  = memaddr;
    assign wr_data  = memi;
`endif

    // Array write port; kept reset-free so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered reads sample the array before this edge's write (read-first).
    always_ff @(posedge clk) begin
        if (rst || clearing) begin
            memo  <= '0;
            memo2 <= '0;
        end else begin
            memo  <= ra_ok ? mem[rmemaddr]  : '0;
            memo2 <= rb_ok ? mem[rmemaddr2] : '0;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed cases plus random traffic against an array model.
// Covers both builds; the clear-sweep checks compile in with MEMORY_CLEAR_EN.
module tb_memory;

    localparam int DEPTH = 40000;

    logic        clk = 1'b0;
    logic        rst;
    logic        memw;
    logic [15:0] memaddr;
    logic [15:0] rmemaddr;
    logic [15:0] rmemaddr2;
    logic [2:0]  memi;
    logic [2:0]  memo;
    logic [2:0]  memo2;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] model [DEPTH];

    memory dut (
        .clk      (clk),
        .rst      (rst),
        .memw     (memw),
        .memaddr  (memaddr),
        .rmemaddr (rmemaddr),
        .rmemaddr2(rmemaddr2),
        .memi     (memi),
        .memo     (memo),
        .memo2    (memo2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_rd(input int a);
        return (a < DEPTH) ? model[a] : 3'b000;
    endfunction

    // Random address from a low window or a window straddling the top of the array.
    function automatic int pick();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 63));
        return int'($urandom_range(DEPTH - 64, DEPTH + 63));
    endfunction

    // One clock: drive inputs, predict both read ports from the model, then check.
    task automatic step(input logic w, input int wa, input logic [2:0] wd,
                        input int ra, input int rb, input logic r, input string tag);
        logic [2:0] ea;
        logic [2:0] eb;
        @(negedge clk);
        rst       = r;
        memw      = w;
        memaddr   = 16'(wa);
        memi      = wd;
        rmemaddr  = 16'(ra);
        rmemaddr2 = 16'(rb);
        ea = r ? 3'b000 : ref_rd(ra);
        eb = r ? 3'b000 : ref_rd(rb);
        if (w && !r && wa < DEPTH) model[wa] = wd;
        @(posedge clk);
        #1;
        chk({tag, "_a"}, memo, ea);
        chk({tag, "_b"}, memo2, eb);
    endtask

`ifdef MEMORY_CLEAR_EN
    // Run n sweep cycles; reads must be 0, and a write to address 0 at cycle wr_at must be dropped.
    task automatic sweep(input int n, input int wr_at, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b0;
            memw      = (i == wr_at);
            memaddr   = 16'd0;
            memi      = 3'b111;
            rmemaddr  = 16'd0;
            rmemaddr2 = 16'(DEPTH - 1);
            @(posedge clk);
            #1;
            if (i % 8000 == 0 || i == n - 1) begin
                chk({tag, "_a"}, memo, 3'b000);
                chk({tag, "_b"}, memo2, 3'b000);
            end
        end
        memw = 1'b0;
        if (n == DEPTH) begin
            for (int k = 0; k < DEPTH; k++) model[k] = 3'b000;
        end
    endtask
`endif

    initial begin
        rst = 1'b1; memw = 1'b0; memaddr = '0; memi = '0; rmemaddr = '0; rmemaddr2 = '0;
        for (int k = 0; k < DEPTH; k++) model[k] = 3'b000;

        // Reset state: outputs zero.
        step(1'b0, 0, 3'b000, 0, 0, 1'b1, "rst0");
`ifdef MEMORY_CLEAR_EN
        sweep(DEPTH, DEPTH - 10, "sweep0");
`else
        step(1'b0, 0, 3'b000, 0, 0, 1'b1, "rst1");
`endif

        // Give every address the random traffic can read a known value.
        for (int k = 0; k < 64; k++) step(1'b1, k, 3'($urandom), 0, 0, 1'b0, "fill_lo");
        for (int k = DEPTH - 64; k < DEPTH; k++) step(1'b1, k, 3'($urandom), 0, 0, 1'b0, "fill_hi");

        // Write 5 then read it back one cycle later.
        step(1'b1, 5, 3'b101, 0, 1, 1'b0, "w5");
        step(1'b0, 0, 3'b000, 5, 5, 1'b0, "r5");

        // Read-first on a same-edge read/write collision.
        step(1'b1, 7, 3'b001, 0, 0, 1'b0, "w7old");
        step(1'b1, 7, 3'b110, 7, 7, 1'b0, "rw7");
        step(1'b0, 0, 3'b000, 7, 7, 1'b0, "r7new");

        // Top address accepted, DEPTH dropped, address 0 untouched.
        step(1'b1, DEPTH - 1, 3'b111, 0, 0, 1'b0, "wlast");
        step(1'b1, DEPTH,     3'b010, 0, 0, 1'b0, "wover");
        step(1'b0, 0, 3'b000, DEPTH - 1, DEPTH, 1'b0, "rlast_over");
        step(1'b0, 0, 3'b000, 0, DEPTH + 5, 1'b0, "r0_over");

        // Both read ports on the same address.
        step(1'b1, 10, 3'b011, 0, 0, 1'b0, "w10");
        step(1'b0, 0, 3'b000, 10, 10, 1'b0, "r10x2");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), pick(), 3'($urandom), pick(), pick(), 1'b0, "rand");
        end

`ifdef MEMORY_CLEAR_EN
        // Sweep clears filled data, restarts on re-reset, then normal writes resume.
        step(1'b1, 0, 3'b101, 0, 0, 1'b0, "cw0");
        step(1'b1, DEPTH - 1, 3'b110, 0, 0, 1'b0, "cwlast");
        step(1'b0, 0, 3'b000, 0, DEPTH - 1, 1'b0, "cr_pre");
        step(1'b0, 0, 3'b000, 0, DEPTH - 1, 1'b1, "crst");
        sweep(50, -1, "sweep_part");
        step(1'b0, 0, 3'b000, 0, DEPTH - 1, 1'b1, "crst2");
        sweep(DEPTH, DEPTH - 10, "sweep1");
        step(1'b0, 0, 3'b000, 0, DEPTH - 1, 1'b0, "cr_post");
        step(1'b1, DEPTH - 1, 3'b011, 0, 0, 1'b0, "cw_new");
        step(1'b0, 0, 3'b000, DEPTH - 1, 0, 1'b0, "cr_new");
`else
        // Reset only zeroes outputs; writes during reset are dropped; data survives.
        step(1'b1, 20, 3'b100, 0, 0, 1'b0, "w20");
        step(1'b0, 0, 3'b000, 5, 20, 1'b0, "pre_rst");
        step(1'b1, 20, 3'b011, 5, 20, 1'b1, "rst_pulse");
        step(1'b0, 0, 3'b000, 5, 20, 1'b0, "post_rst");
        step(1'b1, 20, 3'b010, 0, 0, 1'b0, "w_after_rst");
        step(1'b0, 0, 3'b000, 20, 5, 1'b0, "r_after_rst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
